// File: rtl/cache_defines.sv
// Shared parameters, address field positions and FSM encoding for the data cache.
package cache_defines;

    localparam int SET_COUNT   = 64;
    localparam int INDEX_WIDTH = $clog2(SET_COUNT);
    localparam int TAG_WIDTH   = 10;

    localparam int OFFSET_BIT = 0;
    localparam int INDEX_LSB  = 1;
    localparam int INDEX_MSB  = 6;
    localparam int TAG_LSB    = 7;
    localparam int TAG_MSB    = 16;

    localparam logic [1:0] STATE_IDLE      = 2'd0;
    localparam logic [1:0] STATE_READ_MISS = 2'd1;
    localparam logic [1:0] STATE_WRITE     = 2'd2;

    function automatic logic [31:0] select_word(input logic [63:0] block, input logic sel);
        return sel ? block[63:32] : block[31:0];
    endfunction

endpackage

// File: rtl/dcache_way_array.sv
// Two-way tag/data/valid/LRU storage with registered updates and combinational lookup.
module dcache_way_array
    import cache_defines::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_WIDTH-1:0] index,
    input  logic [TAG_WIDTH-1:0]   tag,
    input  logic                   fill_en,
    input  logic                   fill_way,
    input  logic [63:0]            fill_data,
    input  logic                   write_en,
    input  logic                   write_way,
    input  logic                   write_word,
    input  logic [31:0]            write_data,
    input  logic                   lru_en,
    input  logic                   lru_value,
    output logic                   hit,
    output logic                   hit_way,
    output logic                   lru_way,
    output logic [63:0]            hit_block
);

    logic [SET_COUNT-1:0] valid [2];
    logic [SET_COUNT-1:0] lru;
    logic [TAG_WIDTH-1:0] tag_mem  [2][SET_COUNT];
    logic [63:0]          data_mem [2][SET_COUNT];
    logic                 hit0;
    logic                 hit1;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid[0] <= '0;
            valid[1] <= '0;
            lru      <= '0;
        end else begin
            if (fill_en)
                valid[fill_way][index] <= 1'b1;
            if (lru_en)
                lru[index] <= lru_value;
        end
    end

    // NOTE: tag and data arrays carry no reset; valid bits alone decide whether their contents count.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_way][index]  <= tag;
            data_mem[fill_way][index] <= fill_data;
        end
        if (write_en) begin
            if (write_word)
                data_mem[write_way][index][63:32] <= write_data;
            else
                data_mem[write_way][index][31:0]  <= write_data;
        end
    end

    assign hit0      = valid[0][index] && (tag_mem[0][index] == tag);
    assign hit1      = valid[1][index] && (tag_mem[1][index] == tag);
    assign hit       = hit0 || hit1;
    assign hit_way   = !hit0;
    assign lru_way   = lru[index];
    assign hit_block = data_mem[hit_way][index];

endmodule

// File: rtl/dcache_controller.sv
// Write-through, no-write-allocate 2-way data cache fronting sram_controller.
module dcache_controller
    import cache_defines::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic [31:0] address_in,
    input  logic [31:0] write_data_in,
    output logic [31:0] read_data_out,
    output logic        ready_out,
    output logic        sram_r_en_out,
    output logic        sram_w_en_out,
    output logic [31:0] sram_address_out,
    output logic [31:0] sram_write_data_out,
    input  logic [63:0] sram_read_data_in,
    input  logic        sram_ready_in
);

    logic [1:0]             state;
    logic [1:0]             state_next;
    logic [INDEX_WIDTH-1:0] index;
    logic [TAG_WIDTH-1:0]   tag;
    logic                   word_sel;
    logic                   hit;
    logic                   hit_way;
    logic                   lru_way;
    logic [63:0]            hit_block;
    logic                   fill_en;
    logic                   write_en;
    logic                   lru_en;
    logic                   lru_value;

    assign index    = address_in[INDEX_MSB:INDEX_LSB];
    assign tag      = address_in[TAG_MSB:TAG_LSB];
    assign word_sel = address_in[OFFSET_BIT];

    dcache_way_array u_way_array (
        .clk        (clk),
        .rst        (rst),
        .index      (index),
        .tag        (tag),
        .fill_en    (fill_en),
        .fill_way   (lru_way),
        .fill_data  (sram_read_data_in),
        .write_en   (write_en),
        .write_way  (hit_way),
        .write_word (word_sel),
        .write_data (write_data_in),
        .lru_en     (lru_en),
        .lru_value  (lru_value),
        .hit        (hit),
        .hit_way    (hit_way),
        .lru_way    (lru_way),
        .hit_block  (hit_block)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            state <= STATE_IDLE;
        else
            state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next    = state;
        ready_out     = 1'b0;
        read_data_out = '0;
        fill_en       = 1'b0;
        write_en      = 1'b0;
        lru_en        = 1'b0;
        lru_value     = 1'b0;
        case (state)
            STATE_IDLE: begin
                if (mem_w_en_in) begin
                    state_next = STATE_WRITE;
                end else if (mem_r_en_in) begin
                    if (hit) begin
                        ready_out     = 1'b1;
                        read_data_out = select_word(hit_block, word_sel);
                        lru_en        = 1'b1;
                        lru_value     = !hit_way;
                    end else begin
                        state_next = STATE_READ_MISS;
                    end
                end else begin
                    ready_out = 1'b1;
                end
            end
            STATE_READ_MISS: begin
                if (sram_ready_in) begin
                    fill_en       = 1'b1;
                    lru_en        = 1'b1;
                    lru_value     = !lru_way;
                    read_data_out = select_word(sram_read_data_in, word_sel);
                    ready_out     = 1'b1;
                    state_next    = STATE_IDLE;
                end
            end
            STATE_WRITE: begin
                if (sram_ready_in) begin
                    // No allocate on a write miss: only a hitting line is touched.
                    write_en   = hit;
                    lru_en     = hit;
                    lru_value  = !hit_way;
                    ready_out  = 1'b1;
                    state_next = STATE_IDLE;
                end
            end
            default: state_next = STATE_IDLE;
        endcase
    end

    assign sram_r_en_out       = (state == STATE_READ_MISS);
    assign sram_w_en_out       = (state == STATE_WRITE);
    assign sram_address_out    = address_in;
    assign sram_write_data_out = write_data_in;

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench: directed scenarios plus random traffic against an LRU/backing-memory model.
module tb_dcache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic [31:0] address_in;
    logic [31:0] write_data_in;
    logic [31:0] read_data_out;
    logic        ready_out;
    logic        sram_r_en_out;
    logic        sram_w_en_out;
    logic [31:0] sram_address_out;
    logic [31:0] sram_write_data_out;
    logic [63:0] sram_read_data_in;
    logic        sram_ready_in;

    int errors = 0;
    int checks = 0;

    // Backing memory (word addressed) and per-set recency lists of tags, most recent first.
    logic [31:0] mem_word [bit [16:0]];
    logic [9:0]  recent [64][$];

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem_r_en_in         (mem_r_en_in),
        .mem_w_en_in         (mem_w_en_in),
        .address_in          (address_in),
        .write_data_in       (write_data_in),
        .read_data_out       (read_data_out),
        .ready_out           (ready_out),
        .sram_r_en_out       (sram_r_en_out),
        .sram_w_en_out       (sram_w_en_out),
        .sram_address_out    (sram_address_out),
        .sram_write_data_out (sram_write_data_out),
        .sram_read_data_in   (sram_read_data_in),
        .sram_ready_in       (sram_ready_in)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    function automatic logic [31:0] get_word(input logic [31:0] addr);
        if (!mem_word.exists(addr[16:0]))
            mem_word[addr[16:0]] = $urandom;
        return mem_word[addr[16:0]];
    endfunction

    function automatic bit model_hit(input logic [31:0] addr);
        foreach (recent[addr[6:1]][i])
            if (recent[addr[6:1]][i] == addr[16:7])
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_touch(input logic [31:0] addr);
        int s = int'(addr[6:1]);
        for (int i = recent[s].size() - 1; i >= 0; i--)
            if (recent[s][i] == addr[16:7])
                recent[s].delete(i);
        recent[s].push_front(addr[16:7]);
        if (recent[s].size() > 2)
            void'(recent[s].pop_back());
    endtask

    task automatic model_invalidate();
        for (int s = 0; s < 64; s++)
            recent[s].delete();
    endtask

    task automatic check_idle(input string name);
        check({name, "_ready"}, ready_out, 1'b1);
        check({name, "_rdata"}, read_data_out, 32'h0);
        check({name, "_en"}, {sram_r_en_out, sram_w_en_out}, 2'b00);
    endtask

    // Entered and left just after a rising edge. One request, then an optional idle cycle.
    task automatic do_access(input bit is_write, input bit both, input logic [31:0] addr,
                             input logic [31:0] wdata, input bit gap);
        bit exp_hit = !is_write && model_hit(addr);
        mem_w_en_in   = is_write;
        mem_r_en_in   = !is_write || both;
        address_in    = addr;
        write_data_in = wdata;
        @(negedge clk);
        if (exp_hit) begin
            check("hit_ready", ready_out, 1'b1);
            check("hit_rdata", read_data_out, get_word(addr));
            check("hit_no_en", {sram_r_en_out, sram_w_en_out}, 2'b00);
            model_touch(addr);
            @(posedge clk); #1;
        end else begin
            check("req_ready", ready_out, 1'b0);
            for (int c = 1; c <= 6; c++) begin
                @(posedge clk); #1;
                if (c == 6) begin
                    sram_ready_in     = 1'b1;
                    sram_read_data_in = {get_word({addr[31:1], 1'b1}), get_word({addr[31:1], 1'b0})};
                end
                @(negedge clk);
                check("sram_r_en", sram_r_en_out, !is_write);
                check("sram_w_en", sram_w_en_out, is_write);
                check("sram_addr", sram_address_out, addr);
                if (is_write)
                    check("sram_wdata", sram_write_data_out, wdata);
                check("acc_ready", ready_out, c == 6);
                if (c == 6)
                    check("acc_rdata", read_data_out, is_write ? 32'h0 : get_word(addr));
            end
            @(posedge clk); #1;
            sram_ready_in     = 1'b0;
            sram_read_data_in = {$urandom, $urandom};
            if (is_write) begin
                mem_word[addr[16:0]] = wdata;
                if (model_hit(addr))
                    model_touch(addr);
            end else begin
                model_touch(addr);
            end
        end
        if (gap) begin
            mem_r_en_in = 1'b0;
            mem_w_en_in = 1'b0;
            @(negedge clk);
            check_idle("gap");
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst               = 1'b1;
        mem_r_en_in       = 1'b0;
        mem_w_en_in       = 1'b0;
        address_in        = '0;
        write_data_in     = '0;
        sram_ready_in     = 1'b0;
        sram_read_data_in = '0;
        mem_word[17'h84]  = 32'hAAAAAAAA;
        mem_word[17'h85]  = 32'hBBBBBBBB;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1;

        // Cold miss, hit on the other word, then set-2 conflicts exercising LRU.
        do_access(1'b0, 1'b0, 32'h84,  32'h0, 1'b1);
        do_access(1'b0, 1'b0, 32'h85,  32'h0, 1'b1);
        do_access(1'b0, 1'b0, 32'h104, 32'h0, 1'b1);
        do_access(1'b0, 1'b0, 32'h184, 32'h0, 1'b1);
        do_access(1'b0, 1'b0, 32'h104, 32'h0, 1'b1);
        do_access(1'b0, 1'b0, 32'h84,  32'h0, 1'b1);
        // Write hit then read back; write miss then read must miss.
        do_access(1'b1, 1'b0, 32'h84,  32'h12345678, 1'b1);
        do_access(1'b0, 1'b0, 32'h84,  32'h0, 1'b1);
        do_access(1'b1, 1'b0, 32'h200, 32'hCAFEF00D, 1'b1);
        do_access(1'b0, 1'b0, 32'h200, 32'h0, 1'b0);
        do_access(1'b0, 1'b0, 32'h201, 32'h0, 1'b1);

        // Reset in cycle 3 of a miss: fill dropped and cache invalidated.
        mem_r_en_in = 1'b1;
        address_in  = 32'h300;
        @(negedge clk);
        check("rm_ready0", ready_out, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            if (c == 3)
                rst = 1'b1;
            @(negedge clk);
            check("rm_r_en", sram_r_en_out, 1'b1);
        end
        @(posedge clk); #1;
        rst         = 1'b0;
        mem_r_en_in = 1'b0;
        @(negedge clk);
        check_idle("rm_after");
        @(posedge clk); #1;
        model_invalidate();
        do_access(1'b0, 1'b0, 32'h84, 32'h0, 1'b1);

        // Random traffic over a few sets and tags so conflicts and evictions are frequent.
        for (int n = 0; n < 120; n++) begin
            logic [31:0] a;
            int          kind;
            a    = {15'h0, 8'($urandom_range(0, 3)), 1'b0, 7'h0}
                 | {25'h0, 5'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1))};
            a[16:7] = 10'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 9));
            do_access(kind < 3, kind == 0, a, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
